uart_tx_core: RTL and testbench

UART_TX_CORE -- requirements
Module: uart_tx_core

---
 rtl/uart_tx_core.sv | 99 +++++++++
 tb/tb_uart_tx_core.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_core.sv
// UART transmitter: 8N1 frames, BAUD_DIV clocks per bit, started by a rising edge on tx_start.
// Requests are only taken in IDLE, so edges seen while a frame is in flight are dropped.
module uart_tx_core #(
   parameter int unsigned BAUD_DIV = 868
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       tx,
   output logic       tx_busy,
   output logic       tx_done
);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

   state_t      state;
   logic        d1, d2;
   logic [15:0] baud_cnt;
   logic [2:0]  bit_idx;
   logic [7:0]  shreg;
   logic        start_rise;
   logic        baud_end;

   assign start_rise = d1 & ~d2;
   assign baud_end   = (baud_cnt == BAUD_LAST);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         d1       <= 1'b0;
         d2       <= 1'b0;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         tx       <= 1'b1;
         tx_busy  <= 1'b0;
         tx_done  <= 1'b0;
      end else begin
         d1      <= tx_start;
         d2      <= d1;
         tx_done <= 1'b0;
         case (state)
            IDLE: begin
               baud_cnt <= '0;
               bit_idx  <= '0;
               tx       <= 1'b1;
               tx_busy  <= 1'b0;
               if (start_rise) begin
                  state   <= START;
                  shreg   <= tx_data;
                  tx      <= 1'b0;
                  tx_busy <= 1'b1;
               end
            end
            START: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  state    <= DATA;
                  tx       <= shreg[0];
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            DATA: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     bit_idx <= '0;
                     state   <= STOP;
                     tx      <= 1'b1;
                  end else begin
                     // shreg[0] is the bit on the line; present the next one as we shift
                     bit_idx <= bit_idx + 3'd1;
                     shreg   <= {1'b0, shreg[7:1]};
                     tx      <= shreg[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            STOP: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  state    <= IDLE;
                  tx_busy  <= 1'b0;
                  tx_done  <= 1'b1;
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_core.sv
// Bench for uart_tx_core: a small-divisor instance for most scenarios, a default-divisor one for timing.
// Expected line waveforms come from the 8N1 frame rule: {stop, data, start}, each bit held for the divisor.
module tb_uart_tx_core;

   localparam int BD     = 4;
   localparam int BD_DEF = 868;

   logic       clk = 1'b0;
   logic       rstn;
   logic       s_start, d_start;
   logic [7:0] s_data, d_data;
   logic       s_tx, s_busy, s_done;
   logic       d_tx, d_busy, d_done;
   logic       use_def = 1'b0;
   logic       c_tx, c_busy, c_done;

   int vec = 0;
   int err = 0;

   always #5 clk = ~clk;

   assign c_tx   = use_def ? d_tx   : s_tx;
   assign c_busy = use_def ? d_busy : s_busy;
   assign c_done = use_def ? d_done : s_done;

   uart_tx_core #(.BAUD_DIV(BD)) dut (
      .clk(clk), .rstn(rstn), .tx_start(s_start), .tx_data(s_data),
      .tx(s_tx), .tx_busy(s_busy), .tx_done(s_done)
   );

   uart_tx_core dut_def (
      .clk(clk), .rstn(rstn), .tx_start(d_start), .tx_data(d_data),
      .tx(d_tx), .tx_busy(d_busy), .tx_done(d_done)
   );

   // Reference: line value for each bit slot, index 0 = start bit, index 9 = stop bit.
   function automatic logic [9:0] frame_model(input logic [7:0] b);
      return {1'b1, b, 1'b0};
   endfunction

   // Observes one frame on the selected instance; records only, judging is left to each test.
   task automatic capture(output int lat, output logic [9:0] bits, output int unstable,
                          output int busy_bad, output logic [4:0] tail);
      int bd = use_def ? BD_DEF : BD;
      lat = -1; bits = 'x; unstable = 0; busy_bad = 0; tail = 'x;
      for (int i = 1; i <= 50; i++) begin
         @(negedge clk);
         if (c_tx === 1'b0) begin lat = i; break; end
      end
      if (lat < 0) return;
      for (int k = 0; k < 10 * bd; k++) begin
         if (k != 0) @(negedge clk);
         if (k % bd == 0) bits[k / bd] = c_tx;
         else if (c_tx !== bits[k / bd]) unstable++;
         if (c_busy !== 1'b1 || c_done !== 1'b0) busy_bad++;
      end
      @(negedge clk);
      tail[4] = c_done; tail[3] = c_busy; tail[2] = c_tx;
      @(negedge clk);
      tail[1] = c_done; tail[0] = c_tx;
   endtask

   task automatic test_reset;
      int lat, uns, bb; logic [9:0] bits; logic [4:0] tail; logic [7:0] b;
      rstn = 1'b1; s_start = 0; d_start = 0; s_data = 0; d_data = 0;
      #1 rstn = 1'b0;
      repeat (3) @(negedge clk);
      vec++; if ({s_tx, s_busy, s_done} !== 3'b100) begin err++; $display("FAIL reset.small got %b exp 100", {s_tx, s_busy, s_done}); end
      vec++; if ({d_tx, d_busy, d_done} !== 3'b100) begin err++; $display("FAIL reset.default got %b exp 100", {d_tx, d_busy, d_done}); end
      // tx_start already high when reset releases counts as a rising edge
      b = 8'($urandom); s_data = b; s_start = 1'b1;
      @(negedge clk); rstn = 1'b1;
      fork
         capture(lat, bits, uns, bb, tail);
         begin repeat (3) @(negedge clk); s_start = 1'b0; end
      join
      vec++; if (lat !== 2) begin err++; $display("FAIL reset.release_latency got %0d exp 2", lat); end
      vec++; if (bits !== frame_model(b)) begin err++; $display("FAIL reset.release_bits got %b exp %b", bits, frame_model(b)); end
      vec++; if (tail !== 5'b10101) begin err++; $display("FAIL reset.release_tail got %b exp 10101", tail); end
   endtask

   task automatic test_basic;
      int lat, uns, bb; logic [9:0] bits; logic [4:0] tail;
      repeat (2) @(negedge clk);
      s_data = 8'hA5; s_start = 1'b1;
      fork
         capture(lat, bits, uns, bb, tail);
         begin @(negedge clk); s_start = 1'b0; end
      join
      vec++; if (lat !== 2) begin err++; $display("FAIL basic.latency got %0d exp 2", lat); end
      vec++; if (bits !== frame_model(8'hA5)) begin err++; $display("FAIL basic.bits got %b exp %b", bits, frame_model(8'hA5)); end
      vec++; if (uns !== 0) begin err++; $display("FAIL basic.bit_width unstable cycles got %0d exp 0", uns); end
      vec++; if (bb !== 0) begin err++; $display("FAIL basic.busy_during_frame bad cycles got %0d exp 0", bb); end
      vec++; if (tail !== 5'b10101) begin err++; $display("FAIL basic.done_tail got %b exp 10101", tail); end
   endtask

   task automatic test_random;
      int lat, uns, bb, w; logic [9:0] bits; logic [4:0] tail; logic [7:0] b;
      for (int n = 0; n < 6; n++) begin
         repeat ($urandom_range(1, 8)) @(negedge clk);
         b = 8'($urandom); w = $urandom_range(1, 2);
         s_data = b; s_start = 1'b1;
         fork
            capture(lat, bits, uns, bb, tail);
            begin
               repeat (w) @(negedge clk); s_start = 1'b0;
               repeat (3 - w) @(negedge clk); s_data = ~b;
            end
         join
         vec++; if (lat !== 2) begin err++; $display("FAIL random%0d.latency got %0d exp 2", n, lat); end
         vec++; if (bits !== frame_model(b)) begin err++; $display("FAIL random%0d.bits got %b exp %b", n, bits, frame_model(b)); end
         vec++; if (uns + bb !== 0) begin err++; $display("FAIL random%0d.timing bad cycles got %0d exp 0", n, uns + bb); end
         vec++; if (tail !== 5'b10101) begin err++; $display("FAIL random%0d.tail got %b exp 10101", n, tail); end
      end
   endtask

   task automatic test_held;
      int lat, uns, bb, lows, dones; logic [9:0] bits; logic [4:0] tail;
      lows = 0; dones = 0;
      repeat (2) @(negedge clk);
      s_data = 8'h00; s_start = 1'b1;
      fork
         begin
            capture(lat, bits, uns, bb, tail);
            for (int i = 0; i < 70; i++) begin
               @(negedge clk);
               if (s_tx !== 1'b1) lows++;
               if (s_done !== 1'b0) dones++;
            end
         end
         begin repeat (100) @(negedge clk); s_start = 1'b0; end
      join
      vec++; if (bits !== frame_model(8'h00)) begin err++; $display("FAIL held.bits got %b exp %b", bits, frame_model(8'h00)); end
      vec++; if (tail !== 5'b10101) begin err++; $display("FAIL held.tail got %b exp 10101", tail); end
      vec++; if (lows + dones !== 0) begin err++; $display("FAIL held.second_frame low/done cycles got %0d exp 0", lows + dones); end
   endtask

   task automatic test_busy_ignore;
      int lat, uns, bb, lows, dones; logic [9:0] bits; logic [4:0] tail; logic [7:0] b;
      lows = 0; dones = 0;
      repeat (2) @(negedge clk);
      b = 8'($urandom_range(0, 254)); s_data = b; s_start = 1'b1;
      fork
         begin
            capture(lat, bits, uns, bb, tail);
            for (int i = 0; i < 12 * BD; i++) begin
               @(negedge clk);
               if (s_tx !== 1'b1) lows++;
               if (s_done !== 1'b0) dones++;
            end
         end
         begin
            @(negedge clk); s_start = 1'b0;
            repeat (11) @(negedge clk); s_start = 1'b1; s_data = 8'hFF;
            @(negedge clk); s_start = 1'b0;
         end
      join
      vec++; if (bits !== frame_model(b)) begin err++; $display("FAIL busy_ignore.bits got %b exp %b", bits, frame_model(b)); end
      vec++; if (tail !== 5'b10101) begin err++; $display("FAIL busy_ignore.tail got %b exp 10101", tail); end
      vec++; if (lows + dones !== 0) begin err++; $display("FAIL busy_ignore.queued_frame low/done cycles got %0d exp 0", lows + dones); end
   endtask

   task automatic test_back_to_back;
      int lat, uns, bb, lat2; logic [9:0] bits, bits2; logic [4:0] tail, tail2;
      logic [7:0] b1, b2; logic found;
      found = 1'b0;
      repeat (2) @(negedge clk);
      b1 = 8'($urandom); b2 = 8'($urandom);
      s_data = b1; s_start = 1'b1;
      fork
         capture(lat, bits, uns, bb, tail);
         begin
            @(negedge clk); s_start = 1'b0;
            for (int i = 0; i < 20 * BD; i++) begin
               @(negedge clk);
               if (s_done === 1'b1) begin found = 1'b1; break; end
            end
            s_start = 1'b1; s_data = b2;
            @(negedge clk); s_start = 1'b0;
         end
      join
      capture(lat2, bits2, uns, bb, tail2);
      vec++; if (found !== 1'b1) begin err++; $display("FAIL b2b.done_seen got %b exp 1", found); end
      vec++; if (tail !== 5'b10101) begin err++; $display("FAIL b2b.gap_tail got %b exp 10101", tail); end
      vec++; if (lat2 !== 1) begin err++; $display("FAIL b2b.second_start got %0d exp 1", lat2); end
      vec++; if (bits !== frame_model(b1)) begin err++; $display("FAIL b2b.bits1 got %b exp %b", bits, frame_model(b1)); end
      vec++; if (bits2 !== frame_model(b2)) begin err++; $display("FAIL b2b.bits2 got %b exp %b", bits2, frame_model(b2)); end
      vec++; if (tail2 !== 5'b10101) begin err++; $display("FAIL b2b.tail2 got %b exp 10101", tail2); end
   endtask

   task automatic test_midframe_reset;
      int lat, uns, bb, bad; logic [9:0] bits; logic [4:0] tail; logic [7:0] b;
      lat = -1; bad = 0;
      repeat (2) @(negedge clk);
      b = 8'($urandom); s_data = b; s_start = 1'b1;
      @(negedge clk); s_start = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (s_tx === 1'b0) begin lat = i; break; end
      end
      vec++; if (lat !== 1) begin err++; $display("FAIL midreset.start got %0d exp 1", lat); end
      repeat (17) @(negedge clk);
      vec++; if ({s_busy, s_tx} !== {1'b1, b[3]}) begin err++; $display("FAIL midreset.in_bit3 got %b exp %b", {s_busy, s_tx}, {1'b1, b[3]}); end
      #2 rstn = 1'b0;
      #1;
      vec++; if ({s_tx, s_busy, s_done} !== 3'b100) begin err++; $display("FAIL midreset.async got %b exp 100", {s_tx, s_busy, s_done}); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (s_tx !== 1'b1 || s_done !== 1'b0) bad++;
      end
      rstn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (s_tx !== 1'b1 || s_done !== 1'b0 || s_busy !== 1'b0) bad++;
      end
      vec++; if (bad !== 0) begin err++; $display("FAIL midreset.quiet bad cycles got %0d exp 0", bad); end
      s_data = 8'h3C; s_start = 1'b1;
      fork
         capture(lat, bits, uns, bb, tail);
         begin @(negedge clk); s_start = 1'b0; end
      join
      vec++; if (bits !== frame_model(8'h3C)) begin err++; $display("FAIL midreset.after_bits got %b exp %b", bits, frame_model(8'h3C)); end
      vec++; if (tail !== 5'b10101) begin err++; $display("FAIL midreset.after_tail got %b exp 10101", tail); end
   endtask

   task automatic test_default;
      int lat, uns, bb; logic [9:0] bits; logic [4:0] tail;
      use_def = 1'b1;
      repeat (2) @(negedge clk);
      d_data = 8'h55; d_start = 1'b1;
      fork
         capture(lat, bits, uns, bb, tail);
         begin repeat (2) @(negedge clk); d_start = 1'b0; end
      join
      use_def = 1'b0;
      vec++; if (lat !== 2) begin err++; $display("FAIL default.latency got %0d exp 2", lat); end
      vec++; if (bits !== frame_model(8'h55)) begin err++; $display("FAIL default.bits got %b exp %b", bits, frame_model(8'h55)); end
      vec++; if (uns + bb !== 0) begin err++; $display("FAIL default.bit_width bad cycles got %0d exp 0", uns + bb); end
      vec++; if (tail !== 5'b10101) begin err++; $display("FAIL default.done_at_8680 got %b exp 10101", tail); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_random();
      test_held();
      test_busy_ignore();
      test_back_to_back();
      test_midframe_reset();
      test_default();
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule
